clock_mode_ctrl: RTL and testbench

Front-panel controller that shares one set of switches and debounced buttons among three timekeeping units: unit 0 is the 12-hour clock, unit 1 is the countdown timer, and unit 2 is the stopwatch. It tracks which unit is selected and holds a latched set/run configuration for every unit, so unselected units keep running. It routes hour/min/sec pulses only to the selected unit and returns the selection to the clock after a period of inactivity. It sits between the debouncers and the unit instances, and drives their `mode_in`/`start_stop`/`*_in` ports and the display multiplexer.

---
 rtl/clock_mode_ctrl.sv | 124 ++++++++++++
 tb/tb_clock_mode_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/clock_mode_ctrl.sv
// Front-panel mode controller: selects one of three timekeeping units, latches
// per-unit set/run levels via pickup arming, routes button pulses, auto-returns on idle.
module clock_mode_ctrl #(
  parameter int unsigned TIMEOUT = 30
) (
  input  logic       clk_1Hz,
  input  logic       resetn,
  input  logic       sel_btn,
  input  logic       set_sw,
  input  logic       run_sw,
  input  logic       hour_btn,
  input  logic       min_btn,
  input  logic       sec_btn,
  output logic [2:0] mode_out,
  output logic [2:0] run_out,
  output logic [2:0] hour_pls,
  output logic [2:0] min_pls,
  output logic [2:0] sec_pls,
  output logic [1:0] disp_sel,
  output logic       armed
);

  typedef enum logic [1:0] {
    SEL_CLK = 2'd0,
    SEL_TMR = 2'd1,
    SEL_SW  = 2'd2
  } sel_e;

  localparam logic [5:0] IDLE_LAST = 6'(TIMEOUT - 1);

  sel_e       sel_q, sel_d;
  logic       armed_q, armed_d;
  logic [2:0] mode_lat_q, mode_lat_d;
  logic [2:0] run_lat_q, run_lat_d;
  logic [2:0] hour_q, hour_d;
  logic [2:0] min_q, min_d;
  logic [2:0] sec_q, sec_d;
  logic [5:0] idle_cnt_q, idle_cnt_d;
  logic       set_q, run_q;

  logic [2:0] sel_oh;
  logic       cur_mode, cur_run, match, sw_chg, active, timeout, route_en;

  always_comb begin
    sel_d      = sel_q;
    armed_d    = armed_q;
    mode_lat_d = mode_lat_q;
    run_lat_d  = run_lat_q;
    idle_cnt_d = idle_cnt_q;
    hour_d     = '0;
    min_d      = '0;
    sec_d      = '0;

    sel_oh   = 3'b001 << sel_q;
    cur_mode = |(mode_lat_q & sel_oh);
    cur_run  = |(run_lat_q & sel_oh);
    match    = (set_sw == cur_mode) && (run_sw == cur_run);
    sw_chg   = (set_sw != set_q) || (run_sw != run_q);
    active   = sel_btn || hour_btn || min_btn || sec_btn || sw_chg;
    timeout  = !active && (sel_q != SEL_CLK) && (idle_cnt_q == IDLE_LAST);
    route_en = armed_q && cur_mode && !cur_run && !sel_btn;

    if (active || timeout || sel_q == SEL_CLK) idle_cnt_d = '0;
    else                                        idle_cnt_d = idle_cnt_q + 6'd1;

    // sel_btn outranks the timeout; either one drops arming and blocks the latch write
    if (sel_btn) begin
      unique case (sel_q)
        SEL_CLK: sel_d = SEL_TMR;
        SEL_TMR: sel_d = SEL_SW;
        default: sel_d = SEL_CLK;
      endcase
      armed_d = 1'b0;
    end else if (timeout) begin
      sel_d   = SEL_CLK;
      armed_d = 1'b0;
    end else begin
      armed_d = armed_q | match;
      if (armed_q) begin
        mode_lat_d = (mode_lat_q & ~sel_oh) | (sel_oh & {3{set_sw}});
        run_lat_d  = (run_lat_q & ~sel_oh) | (sel_oh & {3{run_sw}});
      end
    end

    if (route_en && hour_btn) hour_d = sel_oh;
    if (route_en && min_btn)  min_d  = sel_oh;
    if (route_en && sec_btn)  sec_d  = sel_oh;
  end

  always_ff @(posedge clk_1Hz or negedge resetn) begin
    if (!resetn) begin
      sel_q      <= SEL_CLK;
      armed_q    <= 1'b0;
      mode_lat_q <= '0;
      run_lat_q  <= '0;
      hour_q     <= '0;
      min_q      <= '0;
      sec_q      <= '0;
      idle_cnt_q <= '0;
      set_q      <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      sel_q      <= sel_d;
      armed_q    <= armed_d;
      mode_lat_q <= mode_lat_d;
      run_lat_q  <= run_lat_d;
      hour_q     <= hour_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      idle_cnt_q <= idle_cnt_d;
      set_q      <= set_sw;
      run_q      <= run_sw;
    end
  end

  assign mode_out = mode_lat_q;
  assign run_out  = run_lat_q;
  assign hour_pls = hour_q;
  assign min_pls  = min_q;
  assign sec_pls  = sec_q;
  assign disp_sel = sel_q;
  assign armed    = armed_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Bench for clock_mode_ctrl: vector table through a scoreboard queue, plus
// hand-written timeout, timeout-vs-select and reset sequences.
module tb_clock_mode_ctrl;

  localparam int unsigned TO = 30;

  logic       clk_1Hz = 1'b0;
  logic       resetn  = 1'b0;
  logic       sel_btn = 1'b0, set_sw = 1'b0, run_sw = 1'b0;
  logic       hour_btn = 1'b0, min_btn = 1'b0, sec_btn = 1'b0;
  logic [2:0] mode_out, run_out, hour_pls, min_pls, sec_pls;
  logic [1:0] disp_sel;
  logic       armed;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  clock_mode_ctrl #(.TIMEOUT(TO)) dut (
    .clk_1Hz (clk_1Hz),
    .resetn  (resetn),
    .sel_btn (sel_btn),
    .set_sw  (set_sw),
    .run_sw  (run_sw),
    .hour_btn(hour_btn),
    .min_btn (min_btn),
    .sec_btn (sec_btn),
    .mode_out(mode_out),
    .run_out (run_out),
    .hour_pls(hour_pls),
    .min_pls (min_pls),
    .sec_pls (sec_pls),
    .disp_sel(disp_sel),
    .armed   (armed)
  );

  always #5 clk_1Hz = ~clk_1Hz;

  // inp = {sel, set, run, hour, min, sec}; full=0 checks disp_sel only
  typedef struct {
    logic [5:0] inp;
    logic       full;
    logic [1:0] disp;
    logic       arm;
    logic [2:0] mode, run, hp, mp, sp;
  } vec_t;

  vec_t exp_q[$];

  function automatic vec_t mk(input logic [5:0] inp, input logic [1:0] disp, input logic arm,
                              input logic [2:0] mode, input logic [2:0] run,
                              input logic [2:0] hp, input logic [2:0] mp, input logic [2:0] sp);
    vec_t v;
    v.inp = inp; v.full = 1'b1; v.disp = disp; v.arm = arm;
    v.mode = mode; v.run = run; v.hp = hp; v.mp = mp; v.sp = sp;
    return v;
  endfunction

  function automatic vec_t mkd(input logic [5:0] inp, input logic [1:0] disp);
    vec_t v;
    v = mk(inp, disp, 1'b0, '0, '0, '0, '0, '0);
    v.full = 1'b0;
    return v;
  endfunction

  task automatic check(input string name, input vec_t e);
    logic [17:0] act, req;
    n_tests++;
    if (e.full) begin
      act = {disp_sel, armed, mode_out, run_out, hour_pls, min_pls, sec_pls};
      req = {e.disp, e.arm, e.mode, e.run, e.hp, e.mp, e.sp};
    end else begin
      act = {16'd0, disp_sel};
      req = {16'd0, e.disp};
    end
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got disp/arm/mode/run/hp/mp/sp=%b expected %b", name, act, req);
    end
  endtask

  task automatic step(input string name, input vec_t v);
    vec_t e;
    {sel_btn, set_sw, run_sw, hour_btn, min_btn, sec_btn} = v.inp;
    exp_q.push_back(v);
    @(posedge clk_1Hz);
    #1;
    e = exp_q.pop_front();
    check(name, e);
  endtask

  vec_t tbl[21];
  vec_t zero_v;

  initial begin
    tbl[0]  = mk(6'b000000, 2'd0, 1, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
    tbl[1]  = mk(6'b010000, 2'd0, 1, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000);
    tbl[2]  = mk(6'b010100, 2'd0, 1, 3'b001, 3'b000, 3'b001, 3'b000, 3'b000);
    tbl[3]  = mk(6'b010000, 2'd0, 1, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000);
    tbl[4]  = mk(6'b010100, 2'd0, 1, 3'b001, 3'b000, 3'b001, 3'b000, 3'b000);
    tbl[5]  = mk(6'b010000, 2'd0, 1, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000);
    tbl[6]  = mk(6'b010100, 2'd0, 1, 3'b001, 3'b000, 3'b001, 3'b000, 3'b000);
    tbl[7]  = mk(6'b010000, 2'd0, 1, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000);
    tbl[8]  = mk(6'b010001, 2'd0, 1, 3'b001, 3'b000, 3'b000, 3'b000, 3'b001);
    tbl[9]  = mk(6'b011000, 2'd0, 1, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000);
    tbl[10] = mk(6'b011100, 2'd0, 1, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000);
    tbl[11] = mk(6'b111000, 2'd1, 0, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000);
    tbl[12] = mk(6'b011000, 2'd1, 0, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000);
    tbl[13] = mk(6'b000000, 2'd1, 1, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000);
    tbl[14] = mk(6'b000000, 2'd1, 1, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000);
    tbl[15] = mk(6'b010000, 2'd1, 1, 3'b011, 3'b001, 3'b000, 3'b000, 3'b000);
    tbl[16] = mk(6'b010010, 2'd1, 1, 3'b011, 3'b001, 3'b000, 3'b010, 3'b000);
    tbl[17] = mk(6'b110010, 2'd2, 0, 3'b011, 3'b001, 3'b000, 3'b000, 3'b000);
    tbl[18] = mk(6'b111000, 2'd0, 0, 3'b011, 3'b001, 3'b000, 3'b000, 3'b000);
    tbl[19] = mk(6'b011000, 2'd0, 1, 3'b011, 3'b001, 3'b000, 3'b000, 3'b000);
    tbl[20] = mk(6'b000000, 2'd0, 1, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000);
    zero_v  = mk(6'b000000, 2'd0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);

    // Power-on reset
    repeat (2) @(posedge clk_1Hz);
    #1;
    check("reset_state", zero_v);
    resetn = 1'b1;

    foreach (tbl[i]) step($sformatf("vec%0d", i), tbl[i]);

    // Asynchronous reset mid-operation drops every latched configuration
    #2 resetn = 1'b0;
    #1 check("async_reset", zero_v);
    @(posedge clk_1Hz);
    #1 check("reset_held", zero_v);
    resetn = 1'b1;

    // Timeout from unit 2
    step("toA_sel1", mkd(6'b100000, 2'd1));
    step("toA_sel2", mkd(6'b100000, 2'd2));
    for (int i = 1; i < TO; i++) step($sformatf("toA_idle%0d", i), mkd(6'b000000, 2'd2));
    step("toA_fire", mkd(6'b000000, 2'd0));

    // Switch activity at idle cycle 20 restarts the count
    step("toB_sel1", mkd(6'b100000, 2'd1));
    step("toB_sel2", mkd(6'b100000, 2'd2));
    for (int i = 1; i < 20; i++) step($sformatf("toB_idle%0d", i), mkd(6'b000000, 2'd2));
    step("toB_toggle", mkd(6'b010000, 2'd2));
    for (int i = 1; i < TO; i++) step($sformatf("toB_post%0d", i), mkd(6'b010000, 2'd2));
    step("toB_fire", mkd(6'b010000, 2'd0));
    step("toB_clr", mkd(6'b000000, 2'd0));

    // sel_btn on the cycle the timeout would fire from unit 1
    step("toC_sel1", mkd(6'b100000, 2'd1));
    for (int i = 1; i < TO; i++) step($sformatf("toC_idle%0d", i), mkd(6'b000000, 2'd1));
    step("toC_selwins", mkd(6'b100000, 2'd2));
    step("toC_after", mkd(6'b000000, 2'd2));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
